serial_add_ctrl: RTL and testbench

Bit-serial add/subtract engine that time-multiplexes one instance of the team's `full_adder` cell across a WIDTH-bit operation. It latches two operands on a start handshake and feeds the adder LSB-first, one bit per clock, through a carry flop. It returns the result with carry and signed-overflow flags on a held done/ack handshake. It sits between a requesting controller and the shared 1-bit adder datapath, trading WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_add_ctrl.sv | 87 ++++++++
 tb/tb_serial_add_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract engine built around a single shared full_adder cell.
// Also holds that full_adder cell, so the design is one self-contained file.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0] cnt;
  logic carry, msb_cin, fa_s, fa_co;
  full_adder u_fa (.x(ra[0]), .y(rb[0]), .ci(carry), .s(fa_s), .co(fa_co));
  // cout/ovf are registered on the last RUN edge so they stay put after carry is reloaded by the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
          sum   <= '0;
          cout  <= 1'b0;
          ovf   <= 1'b0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            msb_cin <= carry;
            cout    <= fa_co;
            ovf     <= carry ^ fa_co;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: if (ack) begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and model-checked stimulus for WIDTH=8 and WIDTH=5 instances.
module tb_serial_add_ctrl;
  logic clk = 0, rst_n = 0;
  logic start8 = 0, sub8 = 0, ack8 = 0, start5 = 0, sub5 = 0, ack5 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic [4:0] a5 = 0, b5 = 0, sum5;
  logic busy8, done8, cout8, ovf8, busy5, done5, cout5, ovf5;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .ack(ack8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));
  serial_add_ctrl #(.WIDTH(5)) d5 (.clk(clk), .rst_n(rst_n), .start(start5), .sub(sub5), .a(a5), .b(b5),
    .ack(ack5), .busy(busy5), .done(done5), .sum(sum5), .cout(cout5), .ovf(ovf5));

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic logic obusy(int w); return w == 8 ? busy8 : busy5; endfunction
  function automatic logic odone(int w); return w == 8 ? done8 : done5; endfunction
  function automatic logic [7:0] osum(int w); return w == 8 ? sum8 : {3'b0, sum5}; endfunction
  function automatic logic [1:0] oflags(int w); return w == 8 ? {cout8, ovf8} : {cout5, ovf5}; endfunction

  // Independent reference: wide add for sum/cout, sign-rule for overflow.
  function automatic logic [9:0] model(int w, logic [7:0] av, logic [7:0] bv, logic s);
    logic [8:0] m, t;
    logic [7:0] bb;
    logic sa, sb, ss, ov;
    m  = (9'd1 << w) - 9'd1;
    bb = s ? ~bv : bv;
    t  = ({1'b0, av} & m) + ({1'b0, bb} & m) + {8'd0, s};
    sa = av[w-1];
    sb = bv[w-1];
    ss = t[w-1];
    ov = s ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    return {ov, t[w], t[7:0] & m[7:0]};
  endfunction

  task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic s,
                    input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int n;
    @(negedge clk);
    if (w == 8) begin a8 = av; b8 = bv; sub8 = s; start8 = 1; end
    else begin a5 = av[4:0]; b5 = bv[4:0]; sub5 = s; start5 = 1; end
    @(negedge clk);
    start8 = 0; start5 = 0;
    chk({tag, "_busy"}, obusy(w), 1'b1);
    n = 0;
    while (!odone(w) && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, n, w);
    chk({tag, "_sum"}, osum(w), es);
    chk({tag, "_flags"}, oflags(w), {ec, eo});
    if (w == 8) ack8 = 1; else ack5 = 1;
    @(negedge clk);
    ack8 = 0; ack5 = 0;
    chk({tag, "_idle"}, {obusy(w), odone(w)}, 2'b00);
    chk({tag, "_hold"}, {oflags(w), osum(w)}, {ec, eo, es});
  endtask

  initial begin
    logic [9:0] r;
    logic [7:0] ra, rb;
    logic rs;
    int n, pulses, idles, consec;
    logic prev;
    repeat (2) @(negedge clk);
    chk("rst8", {busy8, done8, cout8, ovf8, sum8}, 12'h000);
    chk("rst5", {busy5, done5, cout5, ovf5, sum5}, 9'h000);
    rst_n = 1;

    op(8, 8'h5A, 8'h3C, 0, 8'h96, 0, 1, "add5a3c");
    op(8, 8'hFF, 8'h01, 0, 8'h00, 1, 0, "addff01");
    op(8, 8'h7F, 8'h01, 0, 8'h80, 0, 1, "add7f01");
    op(8, 8'h10, 8'h20, 1, 8'hF0, 0, 0, "sub1020");
    op(8, 8'h80, 8'h01, 1, 8'h7F, 1, 1, "sub8001");
    op(5, 8'h0F, 8'h01, 0, 8'h10, 0, 1, "w5add");
    op(5, 8'h03, 8'h05, 1, 8'h1E, 0, 0, "w5sub");

    // Starts during RUN and DONE must be ignored.
    @(negedge clk); a8 = 8'h12; b8 = 8'h34; sub8 = 0; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (3) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1; start8 = 1;
    @(negedge clk); start8 = 0;
    chk("ign_run_busy", busy8, 1'b1);
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    chk("ign_run_sum", sum8, 8'h46);
    start8 = 1;
    repeat (2) @(negedge clk);
    start8 = 0;
    chk("ign_done", {busy8, done8, cout8, ovf8, sum8}, 12'hC46);
    ack8 = 1; @(negedge clk); ack8 = 0;
    chk("ign_idle", {busy8, done8}, 2'b00);

    // Asynchronous reset at RUN bit 4.
    @(negedge clk); a8 = 8'h11; b8 = 8'h22; sub8 = 0; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1 chk("arst", {busy8, done8, sum8}, 10'h000);
    @(negedge clk); rst_n = 1;
    op(8, 8'h03, 8'h04, 0, 8'h07, 0, 0, "post_rst");

    // start and ack held high: one-cycle done pulse per op, idle cycle between ops.
    @(negedge clk); a8 = 8'h21; b8 = 8'h13; sub8 = 0; start8 = 1; ack8 = 1;
    pulses = 0; idles = 0; consec = 0; prev = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8) begin
        pulses++;
        chk("b2b_sum", sum8, 8'h34);
      end
      if (done8 && prev) consec++;
      if (!busy8) idles++;
      prev = done8;
    end
    start8 = 0; ack8 = 0;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_consec", consec, 0);
    chk("b2b_idles", idles, 3);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      r = model(8, ra, rb, rs);
      op(8, ra, rb, rs, r[7:0], r[8], r[9], "rnd8");
      ra = 8'($urandom_range(0, 31)); rb = 8'($urandom_range(0, 31)); rs = 1'($urandom);
      r = model(5, ra, rb, rs);
      op(5, ra, rb, rs, r[7:0], r[8], r[9], "rnd5");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
